// File: rtl/execute_stage.sv
// rtl/execute_stage.sv - LEGv8 execute stage: ALU, NZCV status, branch target, sequential multiplier
module execute_stage #(
  parameter int WORD        = 64,
  parameter int MULT_CYCLES = 64
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [WORD-1:0] pc,
  input  logic [WORD-1:0] sign_extended_instr,
  input  logic [WORD-1:0] read_data1,
  input  logic [WORD-1:0] read_data2,
  input  logic [10:0]     opcode,
  input  logic            alu_src,
  input  logic [3:0]      alu_op,
  input  logic            update_sreg,
  input  logic            execute_result_loc,
  input  logic            mult_start,
  output logic [WORD-1:0] branch_alu_result,
  output logic [WORD-1:0] alu_result,
  output logic            zero,
  output logic            negative,
  output logic            carry,
  output logic            overflow,
  output logic            stall,
  output logic            multiplier_done
);

  localparam int SW = $clog2(WORD);
  localparam int CW = $clog2(MULT_CYCLES + 1);

  typedef enum logic {S_IDLE, S_BUSY} state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic [WORD-1:0]   w_b;
  logic [WORD-1:0]   w_alu;
  logic [WORD:0]     w_sum;
  logic              w_c;
  logic              w_v;
  logic              w_n;
  logic              w_z;
  logic              r_n;
  logic              r_z;
  logic              r_c;
  logic              r_v;
  logic [WORD-1:0]   r_ma;
  logic [WORD-1:0]   r_mb;
  logic [WORD-1:0]   r_acc;
  logic [WORD-1:0]   r_product;
  logic [CW-1:0]     r_count;
  logic              r_done;
  logic [WORD-1:0]   w_acc_next;
  logic              w_last;
  logic              w_load;
  logic              w_busy;

  assign w_b = alu_src ? sign_extended_instr : read_data2;

  // Combinational ALU with carry/overflow generation for ADD and SUB
  always_comb begin
    w_alu = '0;
    w_sum = '0;
    w_c   = 1'b0;
    w_v   = 1'b0;
    case (alu_op)
      4'b0000: w_alu = read_data1 & w_b;
      4'b0001: w_alu = read_data1 | w_b;
      4'b0010: begin
        w_sum = {1'b0, read_data1} + {1'b0, w_b};
        w_alu = w_sum[WORD-1:0];
        w_c   = w_sum[WORD];
        w_v   = (read_data1[WORD-1] == w_b[WORD-1]) && (w_alu[WORD-1] != read_data1[WORD-1]);
      end
      4'b0011: w_alu = read_data1 ^ w_b;
      4'b0100: w_alu = read_data1 << w_b[SW-1:0];
      4'b0101: w_alu = read_data1 >> w_b[SW-1:0];
      4'b0110: begin
        w_sum = {1'b0, read_data1} + {1'b0, ~w_b} + {{WORD{1'b0}}, 1'b1};
        w_alu = w_sum[WORD-1:0];
        w_c   = w_sum[WORD];
        w_v   = (read_data1[WORD-1] != w_b[WORD-1]) && (w_alu[WORD-1] != read_data1[WORD-1]);
      end
      4'b0111: w_alu = w_b;
      4'b1100: w_alu = ~(read_data1 | w_b);
      default: w_alu = '0;
    endcase
  end

  assign w_n = w_alu[WORD-1];
  assign w_z = (w_alu == '0);

  // NZCV status register, loaded only by flag-setting instructions
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_n <= 1'b0;
      r_z <= 1'b0;
      r_c <= 1'b0;
      r_v <= 1'b0;
    end else if (update_sreg) begin
      r_n <= w_n;
      r_z <= w_z;
      r_c <= w_c;
      r_v <= w_v;
    end
  end

  // CBZ/CBNZ resolve on the live zero flag; everything else uses the stored one
  assign zero     = (opcode[10:4] == 7'b1011010) ? w_z : r_z;
  assign negative = r_n;
  assign carry    = r_c;
  assign overflow = r_v;

  assign branch_alu_result = pc + {sign_extended_instr[WORD-3:0], 2'b00};
  assign alu_result        = execute_result_loc ? r_product : w_alu;

  assign w_acc_next = r_mb[0] ? (r_acc + r_ma) : r_acc;
  assign w_last     = (r_state == S_BUSY) && (r_count == CW'(MULT_CYCLES - 1));

  // Multiplier state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  // Multiplier next-state logic; requests while busy are ignored
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (mult_start) w_state_next = S_BUSY;
      S_BUSY:  if (w_last)     w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Multiplier control outputs
  always_comb begin
    w_load = (r_state == S_IDLE) && mult_start;
    w_busy = (r_state == S_BUSY);
    stall  = mult_start | w_busy;
  end

  // Shift-add datapath; the visible product only changes when a multiply completes
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ma      <= '0;
      r_mb      <= '0;
      r_acc     <= '0;
      r_product <= '0;
      r_count   <= '0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_load) begin
        r_ma    <= read_data1;
        r_mb    <= read_data2;
        r_acc   <= '0;
        r_count <= '0;
      end else if (w_busy) begin
        r_acc   <= w_acc_next;
        r_ma    <= r_ma << 1;
        r_mb    <= r_mb >> 1;
        r_count <= r_count + CW'(1);
        if (w_last) begin
          r_product <= w_acc_next;
          r_done    <= 1'b1;
        end
      end
    end
  end

  assign multiplier_done = r_done;

endmodule

// File: tb/tb_execute_stage.sv
// tb/tb_execute_stage.sv - directed self-checking bench for execute_stage
module tb_execute_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] pc;
  logic [63:0] sign_extended_instr;
  logic [63:0] read_data1;
  logic [63:0] read_data2;
  logic [10:0] opcode;
  logic        alu_src;
  logic [3:0]  alu_op;
  logic        update_sreg;
  logic        execute_result_loc;
  logic        mult_start;
  logic [63:0] branch_alu_result;
  logic [63:0] alu_result;
  logic        zero;
  logic        negative;
  logic        carry;
  logic        overflow;
  logic        stall;
  logic        multiplier_done;

  int n_cmp = 0;
  int n_err = 0;
  int edges;
  int pulses;

  localparam logic [10:0] OPC_CBZ = 11'b10110100000;
  localparam logic [10:0] OPC_ADD = 11'b10001011000;

  logic [3:0]  t_op  [0:10] = '{4'b0000, 4'b0001, 4'b0011, 4'b0100, 4'b0100, 4'b0101,
                                4'b1100, 4'b0111, 4'b1000, 4'b0010, 4'b1111};
  logic [63:0] t_a   [0:10] = '{64'hF0F0, 64'hF0F0, 64'hFF, 64'h1, 64'h1, 64'h8000_0000_0000_0000,
                                64'h0, 64'h5, 64'h5, 64'hFFFF_FFFF_FFFF_FFFF, 64'h3};
  logic [63:0] t_b   [0:10] = '{64'hFF00, 64'h0F0F, 64'h0F, 64'd63, 64'd64, 64'd4,
                                64'h0, 64'h1234, 64'h7, 64'h1, 64'h4};
  logic [63:0] t_exp [0:10] = '{64'hF000, 64'hFFFF, 64'hF0, 64'h8000_0000_0000_0000, 64'h1,
                                64'h0800_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1234,
                                64'h0, 64'h0, 64'h0};

  execute_stage #(.WORD(64), .MULT_CYCLES(64)) dut (
    .clk                 (clk),
    .reset               (reset),
    .pc                  (pc),
    .sign_extended_instr (sign_extended_instr),
    .read_data1          (read_data1),
    .read_data2          (read_data2),
    .opcode              (opcode),
    .alu_src             (alu_src),
    .alu_op              (alu_op),
    .update_sreg         (update_sreg),
    .execute_result_loc  (execute_result_loc),
    .mult_start          (mult_start),
    .branch_alu_result   (branch_alu_result),
    .alu_result          (alu_result),
    .zero                (zero),
    .negative            (negative),
    .carry               (carry),
    .overflow            (overflow),
    .stall               (stall),
    .multiplier_done     (multiplier_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_alu(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b, input logic upd);
    alu_op      = op;
    read_data1  = a;
    read_data2  = b;
    alu_src     = 1'b0;
    update_sreg = upd;
    #1;
  endtask

  // Start edge is not counted; returns edges until done is first seen
  task automatic run_mult(input logic [63:0] a, input logic [63:0] b, output int n);
    read_data1 = a;
    read_data2 = b;
    mult_start = 1'b1;
    #1;
    check("stall_on_request", {63'd0, stall}, 64'd1);
    step();
    mult_start = 1'b0;
    #1;
    check("stall_while_busy", {63'd0, stall}, 64'd1);
    n = 0;
    while (!multiplier_done && n < 200) begin
      step();
      n++;
    end
    if (!multiplier_done) check("mult_timeout", 64'd0, 64'd1);
  endtask

  initial begin
    reset = 1'b1;
    pc = '0; sign_extended_instr = '0; read_data1 = '0; read_data2 = '0;
    opcode = OPC_ADD; alu_src = 1'b0; alu_op = 4'b0010; update_sreg = 1'b0;
    execute_result_loc = 1'b0; mult_start = 1'b0;
    step();
    check("rst_nzcv", {60'd0, negative, zero, carry, overflow}, 64'd0);
    check("rst_stall_done", {62'd0, stall, multiplier_done}, 64'd0);
    #2 reset = 1'b0;
    step();

    set_alu(4'b0010, 64'd5, 64'd7, 1'b1);
    check("add_result", alu_result, 64'd12);
    opcode = OPC_CBZ; #1;
    check("add_live_z", {63'd0, zero}, 64'd0);
    opcode = OPC_ADD;
    step();
    check("add_flags", {60'd0, negative, zero, carry, overflow}, 64'b0000);

    set_alu(4'b0110, 64'd3, 64'd3, 1'b1);
    check("subs_zero_result", alu_result, 64'd0);
    step();
    check("subs_zero_flags", {60'd0, negative, zero, carry, overflow}, 64'b0110);

    set_alu(4'b0110, 64'h7FFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
    check("subs_ovf_result", alu_result, 64'h8000_0000_0000_0000);
    step();
    check("subs_ovf_flags", {60'd0, negative, zero, carry, overflow}, 64'b1001);
    set_alu(4'b0010, 64'd0, 64'd0, 1'b0);
    step();
    check("flags_hold", {60'd0, negative, zero, carry, overflow}, 64'b1001);

    opcode = OPC_CBZ;
    set_alu(4'b0111, 64'd9, 64'd0, 1'b0);
    check("cbz_live_zero", {63'd0, zero}, 64'd1);
    opcode = OPC_ADD; #1;
    check("noncb_reg_zero", {63'd0, zero}, 64'd0);
    pc = 64'h40;
    sign_extended_instr = 64'hFFFF_FFFF_FFFF_FFFE;
    #1;
    check("branch_target", branch_alu_result, 64'h38);

    for (int i = 0; i < 11; i++) begin
      set_alu(t_op[i], t_a[i], t_b[i], 1'b0);
      check($sformatf("alu_vec%0d", i), alu_result, t_exp[i]);
    end

    set_alu(4'b0010, 64'd10, 64'd99, 1'b0);
    alu_src = 1'b1;
    sign_extended_instr = 64'hFFFF_FFFF_FFFF_FFFF;
    #1;
    check("alu_src_imm", alu_result, 64'd9);

    set_alu(4'b0010, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b1);
    step();
    check("adds_wrap_flags", {60'd0, negative, zero, carry, overflow}, 64'b0110);
    update_sreg = 1'b0;

    run_mult(64'd6, 64'hFFFF_FFFF_FFFF_FFFD, edges);
    check("mult_latency", 64'(edges), 64'd64);
    check("stall_low_at_done", {63'd0, stall}, 64'd0);
    pulses = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (multiplier_done) pulses++;
    end
    check("done_single_pulse", 64'(pulses), 64'd0);
    execute_result_loc = 1'b1;
    #1;
    check("mult_product", alu_result, 64'hFFFF_FFFF_FFFF_FFEE);
    check("product_no_flags", {60'd0, negative, zero, carry, overflow}, 64'b0110);
    execute_result_loc = 1'b0;

    read_data1 = 64'd7;
    read_data2 = 64'd9;
    mult_start = 1'b1;
    step();
    mult_start = 1'b0;
    for (int i = 0; i < 9; i++) step();
    #2 reset = 1'b1;
    #1;
    check("rst_mid_stall_done", {62'd0, stall, multiplier_done}, 64'd0);
    check("rst_mid_nzcv", {60'd0, negative, zero, carry, overflow}, 64'd0);
    execute_result_loc = 1'b1;
    #1;
    check("rst_mid_product", alu_result, 64'd0);
    mult_start = 1'b1;
    #1;
    check("rst_stall_follows_start", {63'd0, stall}, 64'd1);
    mult_start = 1'b0;
    step();
    #2 reset = 1'b0;
    step();

    run_mult(64'd7, 64'd9, edges);
    check("mult2_latency", 64'(edges), 64'd64);
    check("mult2_product", alu_result, 64'd63);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/execute_stage.md
Name: execute_stage

Overview:
- Execute stage of the non-pipelined LEGv8 datapath.
- Computes the 64-bit ALU result and the PC-relative branch target.
- Holds the NZCV status register and a sequential 64x64 multiplier that stalls Decode while busy.
- Sits between Decode (operands and control) and Memory (address, flags, branch resolution).

Parameters:
- WORD, 64, datapath width.
- MULT_CYCLES, 64, iteration edges for one multiply (one multiplier bit per edge).

Ports:
- clk  input  1  stage clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high; clears all state.
- pc  input  64  address of the current instruction.
- sign_extended_instr  input  64  sign-extended immediate/offset from Decode.
- read_data1  input  64  register operand A.
- read_data2  input  64  register operand B.
- opcode  input  11  instruction[31:21].
- alu_src  input  1  0: operand B = read_data2; 1: operand B = sign_extended_instr.
- alu_op  input  4  ALU operation select.
- update_sreg  input  1  latch flags into status register at next edge (flag-setting ops).
- execute_result_loc  input  1  0: alu_result from ALU; 1: from product register.
- mult_start  input  1  request a multiply of read_data1*read_data2.
- branch_alu_result  output  64  pc + (sign_extended_instr << 2).
- alu_result  output  64  selected result; also the memory address.
- zero  output  1  Z for branch resolution.
- negative  output  1  registered N.
- carry  output  1  registered C.
- overflow  output  1  registered V.
- stall  output  1  freeze Decode/PC while a multiply is pending.
- multiplier_done  output  1  one-cycle pulse when the product becomes valid.

Behaviour:
- ALU is combinational, A = read_data1, B per alu_src.
- alu_op encoding:
  - 0000 AND, 0001 ORR, 0010 ADD, 0011 EOR.
  - 0100 LSL A by B[5:0]; 0101 LSR A by B[5:0], logical, zero fill.
  - 0110 SUB (A + ~B + 1), 0111 pass B, 1100 NOR.
  - Any other code yields 0.
- Arithmetic wraps modulo 2^64.
- Live flags:
  - N = result[63]; Z = (result == 0).
  - C = carry out of bit 63 for ADD/SUB; SUB C=1 means no borrow.
  - V = signed overflow for ADD/SUB.
  - C = V = 0 for all other ops.
- Status register {N,Z,C,V}: on rising clk with update_sreg=1, loads the live flags; otherwise holds. Reset value 0000.
- negative/carry/overflow always drive the registered flags.
- zero drives the live Z when opcode[10:4] == 7'b1011010 (CBZ/CBNZ); otherwise the registered Z.
- branch_alu_result is combinational; shift discards the top 2 bits.
- Multiplier states: IDLE, BUSY.
  - IDLE with mult_start=1 at an edge: latch both operands, clear product and counter, go to BUSY.
  - BUSY: each edge performs one shift-add step. On the MULT_CYCLES-th step, product (low 64 bits) is valid, go to IDLE, multiplier_done=1 for exactly that following cycle.
  - mult_start while BUSY is ignored.
- Timing:
  - Product register holds its value until the next multiply completes.
  - Latency: done asserted MULT_CYCLES edges after the start edge.
- stall = mult_start | BUSY (combinational), so it is high from the request until done.
  - Decode must drop mult_start when multiplier_done is seen.
  - stall is low in the cycle done is high.
- execute_result_loc=1 selects the product register for alu_result; flags are not updated from the product.
- Reset (any time, including mid-multiply):
  - State IDLE, counter 0, product 0, status 0.
  - multiplier_done 0, stall = mult_start.
  - Combinational outputs follow their inputs.

Test Plan:
- ADD, alu_src=0: A=5, B=7 -> alu_result=12, live Z=0. With update_sreg=1, after edge N=0, Z=0, C=0, V=0.
- SUBS: A=3, B=3, update_sreg=1 -> alu_result=0. After edge zero=1 (non-CB opcode), carry=1, negative=0.
- SUBS: A=0x7FFF_FFFF_FFFF_FFFF, B=-1 -> result 0x8000_0000_0000_0000; after edge negative=1, overflow=1. Next edge with update_sreg=0 leaves flags unchanged.
- CBZ opcode 10110100000, alu_op=0111, read_data2=0 -> zero=1 live, registered Z=0 ignored. Branch: pc=0x40, offset=-2 -> branch_alu_result=0x38.
- Multiply 6 * -3 via mult_start:
  - stall high immediately.
  - multiplier_done pulses once 64 edges after start.
  - execute_result_loc=1 -> alu_result=0xFFFF_FFFF_FFFF_FFEE.
- Reset asserted 10 edges into a multiply -> stall/done fall immediately, status=0. A fresh mult_start then completes normally in 64 edges.
